// File: rtl/muldiv_seq_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: request ops, FSM states
// and the single-step datapath mode.
package muldiv_seq_unit_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } stepMode_t;

  function automatic logic isIterOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add multiply
// or restoring divide, selected by mode.
module muldiv_step
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  stepMode_t          mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] accNext
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    accNext = acc;
    sum     = '0;
    trial   = '0;
    if (mode == STEP_MUL) begin
      // Lower half holds the unconsumed multiplier bits; the carry shifts into the top.
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      accNext = {sum, acc[WIDTH-1:1]};
    end else begin
      // Remainder < divisor keeps a successful trial within WIDTH bits, so bit WIDTH is the borrow.
      trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
      if (!trial[WIDTH]) begin
        accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        accNext = {acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
// One step per clock, then a single sign-fixup cycle.
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   operand;
  stepMode_t          mode;
  logic               negHi;
  logic               negLo;
  logic               divZero;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               busy;
  logic               done;

  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .mode    (mode),
    .acc     (acc),
    .operand (operand),
    .accNext (accNext)
  );

  // Negating the most negative value in WIDTH bits yields its correct unsigned magnitude.
  always_comb begin
    signA = isSignedOp(iOp) & iA[WIDTH-1];
    signB = isSignedOp(iOp) & iB[WIDTH-1];
    magA  = signA ? -iA : iA;
    magB  = signB ? -iB : iB;
  end

  always_comb begin
    prod  = negLo ? -acc : acc;
    quo   = acc[WIDTH-1:0];
    rem   = acc[2*WIDTH-1:WIDTH];
    fixHi = prod[2*WIDTH-1:WIDTH];
    fixLo = prod[WIDTH-1:0];
    if (mode == STEP_DIV) begin
      // Divide by zero: the remainder path already reproduces the dividend in HI.
      fixLo = divZero ? '1 : (negLo ? -quo : quo);
      fixHi = negHi ? -rem : rem;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_IDLE;
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      mode    <= STEP_MUL;
      negHi   <= 1'b0;
      negLo   <= 1'b0;
      divZero <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            if (isIterOp(iOp)) begin
              if (isDivOp(iOp)) begin
                mode    <= STEP_DIV;
                acc     <= {{WIDTH{1'b0}}, magA};
                operand <= magB;
                negHi   <= signA;
              end else begin
                mode    <= STEP_MUL;
                acc     <= {{WIDTH{1'b0}}, magB};
                operand <= magA;
                negHi   <= signA ^ signB;
              end
              negLo   <= signA ^ signB;
              divZero <= isDivOp(iOp) && (iB == '0);
              count   <= CW'(WIDTH - 1);
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else if (iOp == MD_MTHI) begin
              hiReg <= iA;
            end else if (iOp == MD_MTLO) begin
              loReg <= iA;
            end
          end
        end
        ST_RUN: begin
          acc   <= accNext;
          count <= count - 1'b1;
          if (count == '0) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          hiReg <= fixHi;
          loReg <= fixLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oBusy = busy;
  assign oDone = done;
  assign oHI   = hiReg;
  assign oLO   = loReg;

endmodule
